// File: rtl/my_block_sched.sv
// Frame sequencer for one my_block_top: reference search, one bloom pass per
// non-zero reference slot, then a commit strobe. Reports per-frame status.
module my_block_sched #(
    parameter int DIST_WIDTH = 14,
    parameter int REF_MAX    = 3,
    parameter int CNT_WIDTH  = 2,
    parameter int TIMEOUT    = 255,
    parameter int TO_WIDTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          contains_ref,
    input  logic                          contains_bloom,
    input  logic                          ref_end,
    input  logic                          bloom_end,
    input  logic [REF_MAX*DIST_WIDTH-1:0] ref_dist,
    output logic [1:0]                    mode,
    output logic [DIST_WIDTH-1:0]         distance,
    output logic                          core_end,
    output logic                          busy,
    output logic                          done,
    output logic                          timeout_err,
    output logic [CNT_WIDTH-1:0]          ref_cnt,
    output logic [CNT_WIDTH-1:0]          bloom_cnt
);

    localparam int PTR_W = (REF_MAX > 1) ? $clog2(REF_MAX) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_REF    = 3'd1;
    localparam logic [2:0] S_LATCH  = 3'd2;
    localparam logic [2:0] S_SETTLE = 3'd3;
    localparam logic [2:0] S_BLOOM  = 3'd4;
    localparam logic [2:0] S_COMMIT = 3'd5;
    localparam logic [2:0] S_FINISH = 3'd6;

    logic [2:0]                    state;
    logic [2:0]                    nstate;
    logic                          to_hit;
    logic [TO_WIDTH-1:0]           tcnt;
    logic [PTR_W-1:0]              ptr;
    logic [REF_MAX*DIST_WIDTH-1:0] slot_q;
    logic [REF_MAX-1:0]            in_nz;
    logic [REF_MAX-1:0]            slot_nz;
    logic [PTR_W:0]                first_hit;
    logic [PTR_W:0]                next_hit;
    logic                          pass_expired;

    // Lowest set bit of mask at or above index lo; MSB of the result is "found".
    function automatic logic [PTR_W:0] find_from(input logic [REF_MAX-1:0] mask, input int lo);
        logic [PTR_W:0] r;
        r = '0;
        for (int i = REF_MAX - 1; i >= 0; i--) begin
            if (i >= lo && mask[i]) begin
                r = {1'b1, PTR_W'(i)};
            end
        end
        return r;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] count_nz(input logic [REF_MAX-1:0] mask);
        logic [CNT_WIDTH-1:0] c;
        c = '0;
        for (int i = 0; i < REF_MAX; i++) begin
            if (mask[i]) begin
                c = c + CNT_WIDTH'(1);
            end
        end
        return c;
    endfunction

    function automatic logic [1:0] mode_of(input logic [2:0] s);
        logic [1:0] m;
        m = 2'b00;
        if (s == S_REF) begin
            m = 2'b01;
        end else if (s == S_BLOOM) begin
            m = 2'b10;
        end
        return m;
    endfunction

    always_comb begin
        in_nz   = '0;
        slot_nz = '0;
        for (int i = 0; i < REF_MAX; i++) begin
            in_nz[i]   = |ref_dist[i*DIST_WIDTH +: DIST_WIDTH];
            slot_nz[i] = |slot_q[i*DIST_WIDTH +: DIST_WIDTH];
        end
        first_hit = find_from(in_nz, 0);
        next_hit  = find_from(slot_nz, int'(ptr) + 1);
    end

    // Counter would reach TIMEOUT on this edge; an end strobe on the same edge wins.
    assign pass_expired = (tcnt == TO_WIDTH'(TIMEOUT - 1));

    always_comb begin
        nstate = state;
        to_hit = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    nstate = S_REF;
                end
            end
            S_REF: begin
                if (ref_end) begin
                    nstate = contains_ref ? S_LATCH : S_COMMIT;
                end else if (pass_expired) begin
                    nstate = S_IDLE;
                    to_hit = 1'b1;
                end
            end
            S_LATCH: begin
                nstate = first_hit[PTR_W] ? S_BLOOM : S_COMMIT;
            end
            S_BLOOM: begin
                if (bloom_end) begin
                    nstate = next_hit[PTR_W] ? S_SETTLE : S_COMMIT;
                end else if (pass_expired) begin
                    nstate = S_IDLE;
                    to_hit = 1'b1;
                end
            end
            S_SETTLE: nstate = S_BLOOM;
            S_COMMIT: nstate = S_FINISH;
            S_FINISH: nstate = S_IDLE;
            default:  nstate = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            mode        <= 2'b00;
            distance    <= '0;
            core_end    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            ref_cnt     <= '0;
            bloom_cnt   <= '0;
            tcnt        <= '0;
            ptr         <= '0;
            slot_q      <= '0;
        end else begin
            state       <= nstate;
            mode        <= mode_of(nstate);
            busy        <= (nstate != S_IDLE);
            core_end    <= (nstate == S_COMMIT);
            done        <= (nstate == S_FINISH);
            timeout_err <= to_hit;

            if ((nstate == S_REF && state != S_REF) || (nstate == S_BLOOM && state != S_BLOOM)) begin
                tcnt <= '0;
            end else if (state == S_REF || state == S_BLOOM) begin
                tcnt <= tcnt + TO_WIDTH'(1);
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        ref_cnt   <= '0;
                        bloom_cnt <= '0;
                    end
                end
                S_LATCH: begin
                    slot_q  <= ref_dist;
                    ref_cnt <= count_nz(in_nz);
                    ptr     <= first_hit[PTR_W-1:0];
                    if (first_hit[PTR_W]) begin
                        distance <= ref_dist[int'(first_hit[PTR_W-1:0])*DIST_WIDTH +: DIST_WIDTH];
                    end
                end
                S_BLOOM: begin
                    if (bloom_end) begin
                        if (contains_bloom && bloom_cnt != '1) begin
                            bloom_cnt <= bloom_cnt + CNT_WIDTH'(1);
                        end
                        if (next_hit[PTR_W]) begin
                            ptr <= next_hit[PTR_W-1:0];
                        end
                    end
                end
                S_SETTLE: begin
                    distance <= slot_q[int'(ptr)*DIST_WIDTH +: DIST_WIDTH];
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/my_block_sched.md
# my_block_sched

Sequencer for one `my_block_top` instance. It drives `mode`, `distance` and `core_end`:
- first a reference-search pass;
- then one bloom pass per non-zero reference distance returned;
- finally a one-cycle commit strobe so block memory keeps the updated point notations.

It sits between the frame-level control and each block and reports per-frame status upward.

## Interface
- `DIST_WIDTH`, 14, width of distance values
- `REF_MAX`, 3, reference slots returned by the block
- `CNT_WIDTH`, 2, width of `ref_cnt`/`bloom_cnt`; must satisfy 2^CNT_WIDTH > REF_MAX
- `TIMEOUT`, 255, max cycles in one pass before abort; must be ≥ 2
- `TO_WIDTH`, 8, width of the timeout counter; 2^TO_WIDTH > TIMEOUT
- `clk`  in  1  single clock, all logic rising-edge
- `rst`  in  1  synchronous active-high reset
- `start`  in  1  begin one frame; sampled only in IDLE
- `contains_ref`  in  1  from block; valid with `ref_end`
- `contains_bloom`  in  1  from block; valid with `bloom_end`
- `ref_end`  in  1  block finished reference pass
- `bloom_end`  in  1  block finished bloom pass
- `ref_dist`  in  REF_MAX*DIST_WIDTH  reference distances, slot i at bits [i*DIST_WIDTH +: DIST_WIDTH]; value 0 = empty slot
- `mode`  out  2  00 idle, 01 reference search, 10 bloom removal (11 never driven)
- `distance`  out  DIST_WIDTH  reference distance for current bloom pass
- `core_end`  out  1  one-cycle commit strobe to block memory
- `busy`  out  1  high from accepted `start` until return to IDLE
- `done`  out  1  one-cycle pulse, frame completed normally
- `timeout_err`  out  1  one-cycle pulse, frame aborted
- `ref_cnt`  out  CNT_WIDTH  non-zero reference slots latched this frame
- `bloom_cnt`  out  CNT_WIDTH  bloom passes that reported `contains_bloom`=1

## Operation
- States: IDLE, REF, LATCH, SETTLE, BLOOM, COMMIT, FINISH. All outputs are registered.
- IDLE: mode=00, busy=0. On `start`=1:
  - clear `ref_cnt`, `bloom_cnt` and the timeout counter;
  - go to REF.
- REF: mode=01. On `ref_end`=1, go to LATCH.
  - If `contains_ref`=0 that cycle, go instead to COMMIT with `ref_cnt`=0.
- LATCH (1 cycle): mode=00.
  - Capture all REF_MAX slots into internal registers.
  - `ref_cnt` = number of non-zero slots.
  - Slot pointer = lowest non-zero slot.
  - Go to BLOOM if any slot is non-zero, else COMMIT.
- BLOOM: mode=10, `distance` = latched slot[pointer]. On `bloom_end`=1:
  - `bloom_cnt` += `contains_bloom`, saturating at 2^CNT_WIDTH−1;
  - advance pointer to the next non-zero slot;
  - go to SETTLE if one exists, else COMMIT.
- SETTLE (1 cycle): mode=00, then BLOOM with the new distance. Every mode change passes through 00 for at least one cycle.
- COMMIT (1 cycle): mode=00, `core_end`=1, then FINISH.
- FINISH (1 cycle): `done`=1, then IDLE.
- Empty slots are skipped in slot order. `ref_dist` changes after LATCH are ignored.
- Timeout:
  - The counter resets on entry to REF or BLOOM and increments every cycle in those states.
  - On reaching TIMEOUT with no end strobe: pulse `timeout_err`, go directly to IDLE.
  - No COMMIT and no `done` (block memory is left uncommitted).
- `start` while busy is ignored. `ref_end` and `bloom_end` are ignored outside REF and BLOOM respectively.

## Timing
- Reset values (any state, including mid-frame): state IDLE, mode=00, distance=0, core_end=0, busy=0, done=0, timeout_err=0, ref_cnt=0, bloom_cnt=0, latched slots=0.
  - A reset during BLOOM or COMMIT suppresses the pending `core_end`.
- `start` high at edge N: mode=01 and busy=1 from N+1.
- `ref_end` high at edge M: mode=00 from M+1 (LATCH). First BLOOM has mode=10 from M+2.
- `bloom_end` at edge K:
  - more passes remain: SETTLE at K+1, next BLOOM at K+2;
  - last pass: `core_end` at K+1, `done` at K+2, busy=0 from K+3.
- `distance` is stable during each BLOOM; it updates in the cycle entering BLOOM and holds otherwise.
- `ref_cnt` is valid from LATCH+1. `bloom_cnt` is valid when `done` pulses. Both hold until the next accepted `start`.
- End strobe in the same cycle the counter reaches TIMEOUT: the end strobe wins, no error.
- Minimum frame, `contains_ref`=0 with `ref_end` at first REF cycle: start→done = 4 cycles.

## Test plan
- Reset mid-BLOOM (mode=10): next cycle mode=00, busy=0, counters 0, no `core_end` ever emitted.
- `start`, `ref_end`+`contains_ref`=0 one cycle later → `core_end` 1 cycle, `done` next cycle, ref_cnt=0, bloom_cnt=0, mode never 10.
- ref_dist={slot0=120, slot1=0, slot2=455}; bloom_end after 5 cycles each, contains_bloom=1 then 0:
  - exactly two BLOOM passes with distance 120 then 455, separated by one mode=00 cycle;
  - ref_cnt=2, bloom_cnt=1, single `core_end`, then `done`.
- TIMEOUT=8, `ref_end` never asserted → `timeout_err` pulse 8 cycles after REF entry, mode=00, no `core_end`/`done`; a following `start` runs normally.
- `start` pulsed during BLOOM and `bloom_end` pulsed during REF → both ignored; sequence and counts unchanged versus baseline.
- TIMEOUT=8, `bloom_end` in the same cycle the counter reaches 8 → no `timeout_err`, frame completes with `done`.
